// File: rtl/scb_wb_scheduler.sv
`default_nettype none
// scb_wb_scheduler: issue arbiter and owner of the shared writeback bus (stable reservations + unstable req/ack).
// Optional macro SCB_UST_STARVE_GUARD_EN adds a starvation guard that drains the bus for the unstable pipe.
module scb_wb_scheduler #(
  parameter int N_REQ      = 4,
  parameter int MAX_LAT    = 8,
  parameter int STARVE_LIM = 16,
  parameter int LAT_W      = $clog2(MAX_LAT + 1),
  parameter int SRC_W      = $clog2(N_REQ + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       iss_req,
  input  logic [N_REQ-1:0]       iss_stable,
  input  logic [N_REQ*LAT_W-1:0] iss_lat,
  output logic [N_REQ-1:0]       iss_grant,
  input  logic                   ust_req,
  output logic                   ust_ack,
  output logic                   wb_valid,
  output logic [SRC_W-1:0]       wb_src,
  output logic                   ust_busy
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int EXT_N = 2 ** LAT_W;
  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);
  localparam logic [PTR_W:0]   N_REQ_V   = (PTR_W + 1)'(N_REQ);

  logic [MAX_LAT-1:0] occ_valid;
  logic [SRC_W-1:0]   occ_id [MAX_LAT];
  logic [EXT_N-1:0]   occ_ext;
  logic [PTR_W-1:0]   rr_ptr;
  logic               busy_q;
  logic               starve_blk;
  logic               active;
  logic [LAT_W-1:0]   lat_of [N_REQ];
  logic [N_REQ-1:0]   elig;
  logic [PTR_W:0]     cand;
  logic               gnt_any;
  logic               gnt_fire;
  logic               gnt_stable;
  logic [PTR_W-1:0]   gnt_idx;
  logic [LAT_W-1:0]   gnt_lat;

  assign active = !rst && !flush;

  for (genvar r = 0; r < N_REQ; r++) begin : g_lat
    assign lat_of[r] = iss_lat[r*LAT_W +: LAT_W];
  end

  // Slots at or beyond MAX_LAT read as free, so any latency value can index safely.
  always_comb begin
    occ_ext = '0;
    occ_ext[MAX_LAT-1:0] = occ_valid;
  end

  always_comb begin
    elig = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (iss_stable[r])
        elig[r] = iss_req[r] && (lat_of[r] != '0) && (lat_of[r] <= MAX_LAT_V)
                  && !occ_ext[lat_of[r]] && !starve_blk;
      else
        elig[r] = iss_req[r] && !busy_q;
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (cand >= N_REQ_V) cand = cand - N_REQ_V;
      if (!gnt_any && elig[cand[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
  end

  assign gnt_fire   = gnt_any && active;
  assign gnt_stable = iss_stable[gnt_idx];
  assign gnt_lat    = lat_of[gnt_idx];

  always_comb begin
    iss_grant = '0;
    if (gnt_fire) iss_grant[gnt_idx] = 1'b1;
  end

  assign ust_ack  = ust_req && busy_q && !occ_valid[0] && active;
  assign ust_busy = busy_q && !rst;

  always_comb begin
    wb_valid = 1'b0;
    wb_src   = '0;
    if (active) begin
      if (occ_valid[0]) begin
        wb_valid = 1'b1;
        wb_src   = occ_id[0];
      end else if (ust_ack) begin
        wb_valid = 1'b1;
        wb_src   = SRC_W'(N_REQ);
      end
    end
  end

  // A grant checks occ[L]; after the shift that entry is occ[L-1], so the write never hits a live slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_valid <= '0;
      for (int k = 0; k < MAX_LAT; k++) occ_id[k] <= '0;
      rr_ptr <= '0;
      busy_q <= 1'b0;
    end else if (flush) begin
      occ_valid <= '0;
      busy_q    <= 1'b0;
    end else begin
      occ_valid <= {1'b0, occ_valid[MAX_LAT-1:1]};
      for (int k = 0; k < MAX_LAT - 1; k++) occ_id[k] <= occ_id[k+1];
      occ_id[MAX_LAT-1] <= '0;
      if (gnt_fire && gnt_stable) begin
        for (int k = 0; k < MAX_LAT; k++) begin
          if (gnt_lat == LAT_W'(k + 1)) begin
            occ_valid[k] <= 1'b1;
            occ_id[k]    <= SRC_W'(gnt_idx);
          end
        end
      end
      if (gnt_fire)
        rr_ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      if (ust_ack)
        busy_q <= 1'b0;
      else if (gnt_fire && !gnt_stable)
        busy_q <= 1'b1;
    end
  end

`ifdef SCB_UST_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush || ust_ack)
      starve_cnt <= '0;
    else if (ust_req && (starve_cnt != CNT_W'(STARVE_LIM)))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

  assign starve_blk = (starve_cnt >= CNT_W'(STARVE_LIM));
`else
  logic unused_starve_lim;
  assign unused_starve_lim = (STARVE_LIM > 0);
  assign starve_blk = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scb_wb_scheduler.sv
`default_nettype none
// tb_scb_wb_scheduler: directed + random stimulus against an absolute-time reservation model with a scoreboard.
module tb_scb_wb_scheduler;
  localparam int N_REQ      = 4;
  localparam int MAX_LAT    = 8;
  localparam int STARVE_LIM = 16;
  localparam int LAT_W      = 4;
  localparam int SRC_W      = 3;
`ifdef SCB_UST_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst, flush, ust_req;
  logic [N_REQ-1:0]       iss_req, iss_stable, iss_grant;
  logic [N_REQ*LAT_W-1:0] iss_lat;
  logic                   ust_ack, wb_valid, ust_busy;
  logic [SRC_W-1:0]       wb_src;

  always #5 clk = ~clk;

  scb_wb_scheduler #(
    .N_REQ(N_REQ), .MAX_LAT(MAX_LAT), .STARVE_LIM(STARVE_LIM), .LAT_W(LAT_W), .SRC_W(SRC_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_req(iss_req), .iss_stable(iss_stable), .iss_lat(iss_lat), .iss_grant(iss_grant),
    .ust_req(ust_req), .ust_ack(ust_ack), .wb_valid(wb_valid), .wb_src(wb_src), .ust_busy(ust_busy)
  );

  typedef struct {
    logic [N_REQ-1:0] grant;
    logic             ack;
    logic             wbv;
    logic [SRC_W-1:0] src;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: reservations keyed by the absolute cycle in which the bus is owned.
  int t_now = 0;
  int res[int];
  bit m_busy = 0;
  int m_rr = 0;
  int m_cnt = 0;
  int m_gnt = -1;
  bit m_ack = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("iss_grant", 32'(iss_grant), 32'(e.grant));
      check("ust_ack",   32'(ust_ack),   32'(e.ack));
      check("wb_valid",  32'(wb_valid),  32'(e.wbv));
      check("wb_src",    32'(wb_src),    32'(e.src));
      check("ust_busy",  32'(ust_busy),  32'(e.busy));
    end
  end

  task automatic model_cycle(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] stb,
                             input logic [N_REQ*LAT_W-1:0] lat, input logic fl, input logic ur,
                             input logic rs);
    exp_t e;
    int g, r, l, lg;
    bit occ0, ack, blk;
    e.grant = '0; e.ack = 1'b0; e.wbv = 1'b0; e.src = '0; e.busy = 1'b0;
    g = -1; lg = 0; ack = 0;
    if (rs) begin
      res.delete(); m_busy = 0; m_rr = 0; m_cnt = 0;
    end else if (fl) begin
      e.busy = m_busy;
      res.delete(); m_busy = 0; m_cnt = 0;
    end else begin
      e.busy = m_busy;
      occ0 = res.exists(t_now);
      ack  = ur && m_busy && !occ0;
      blk  = GUARD && (m_cnt >= STARVE_LIM);
      for (int i = 0; i < N_REQ; i++) begin
        r = (m_rr + i) % N_REQ;
        l = int'(lat[r*LAT_W +: LAT_W]);
        if (g < 0 && req[r]) begin
          if (stb[r]) begin
            if (l >= 1 && l <= MAX_LAT && !res.exists(t_now + l) && !blk) begin g = r; lg = l; end
          end else if (!m_busy) g = r;
        end
      end
      if (occ0) begin e.wbv = 1'b1; e.src = SRC_W'(res[t_now]); end
      else if (ack) begin e.wbv = 1'b1; e.src = SRC_W'(N_REQ); end
      e.ack = ack;
      if (g >= 0) e.grant = N_REQ'(1) << g;
      if (occ0) res.delete(t_now);
      if (g >= 0) begin
        if (stb[g]) res[t_now + lg] = g;
        else m_busy = 1;
        m_rr = (g + 1) % N_REQ;
      end
      if (ack) begin m_busy = 0; m_cnt = 0; end
      else if (ur) m_cnt++;
    end
    m_gnt = g;
    m_ack = ack;
    t_now++;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] stb,
                       input logic [N_REQ*LAT_W-1:0] lat, input logic fl, input logic ur,
                       input logic rs);
    rst = rs; flush = fl; iss_req = req; iss_stable = stb; iss_lat = lat; ust_req = ur;
    model_cycle(req, stb, lat, fl, ur, rs);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_REQ*LAT_W-1:0] lat4(input int l0, input int l1, input int l2, input int l3);
    return {LAT_W'(l3), LAT_W'(l2), LAT_W'(l1), LAT_W'(l0)};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) drive('0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [N_REQ-1:0] pend;
  logic             ur_hold;

  initial begin
    rst = 1'b1; flush = 1'b0; ust_req = 1'b0;
    iss_req = '0; iss_stable = '0; iss_lat = '0;
    ur_hold = 1'b0;
    @(posedge clk);
    #1;

    // Single stable request r1, L=3.
    do_reset();
    idle(1);
    drive(4'b0010, 4'b1111, lat4(0, 3, 0, 0), 1'b0, 1'b0, 1'b0);
    idle(5);

    // r0 and r2 contend with L=2; hold each request until it is granted.
    do_reset();
    pend = 4'b0101;
    for (int i = 0; i < 6 && pend != '0; i++) begin
      drive(pend, 4'b1111, lat4(2, 2, 2, 2), 1'b0, 1'b0, 1'b0);
      if (m_gnt >= 0) pend[m_gnt] = 1'b0;
    end
    idle(5);

    // Unstable issue, blocked reissue, deferred ack behind a stable reservation.
    drive(4'b1000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
    drive(4'b1000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 4'b0001, lat4(1, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    ur_hold = 1'b1;
    for (int i = 0; i < 4 && ur_hold; i++) begin
      drive('0, '0, '0, 1'b0, 1'b1, 1'b0);
      if (m_ack) ur_hold = 1'b0;
    end
    idle(2);

    // Out-of-range latencies are never granted.
    drive(4'b0110, 4'b0110, lat4(0, 0, 9, 0), 1'b0, 1'b0, 1'b0);
    drive(4'b0110, 4'b0110, lat4(0, 15, 9, 0), 1'b0, 1'b0, 1'b0);
    idle(2);

    // Flush with pending reservations and a busy unstable pipe.
    drive(4'b1000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 4'b0001, lat4(5, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    drive(4'b0010, 4'b0010, lat4(0, 6, 0, 0), 1'b0, 1'b0, 1'b0);
    drive(4'b0100, 4'b0100, lat4(0, 0, 7, 0), 1'b0, 1'b0, 1'b0);
    drive('0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(9);

    // Continuous L=1 traffic while the unstable result waits.
    drive(4'b1000, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
    ur_hold = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drive(4'b0001, 4'b0001, lat4(1, 0, 0, 0), 1'b0, ur_hold, 1'b0);
      if (m_ack) ur_hold = 1'b0;
    end
    drive('0, '0, '0, 1'b1, 1'b0, 1'b0);
    ur_hold = 1'b0;
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [N_REQ-1:0] rq, sb;
      logic [N_REQ*LAT_W-1:0] lt;
      logic fl, rs;
      rq = N_REQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      sb = N_REQ'($urandom_range(0, 15) | $urandom_range(0, 15));
      lt = (N_REQ*LAT_W)'($urandom);
      fl = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 399) == 0);
      if (!ur_hold && m_busy && $urandom_range(0, 3) == 0) ur_hold = 1'b1;
      drive(rq, sb, lt, fl, ur_hold, rs);
      if (m_ack || fl || rs) ur_hold = 1'b0;
    end
    idle(MAX_LAT + 2);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
